// File: rtl/logic_alu_arbiter.sv
// Two-requester round-robin front end for one 8-bit logic unit (AND/OR/XOR/NOT/MUX/DMUX).
// Latency: 2 cycles from accept to rsp_valid; holds RESP under backpressure; ready is combinational.
module logic_alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic [7:0] done_cnt0,
  output logic [7:0] done_cnt1,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_prio;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  logic       w_rsp_done;

  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_op;
  logic       r_id;

  logic [7:0] w_alu_data;
  logic       w_alu_err;

  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_id;
  logic       r_rsp_err;
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;
  logic       r_busy;

  // Contention goes to the priority holder; a lone requester always wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt0 = ~r_prio;
      w_gnt1 = r_prio;
    end else begin
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready;
  assign req0_ready = (r_state == S_IDLE) && w_gnt0;
  assign req1_ready = (r_state == S_IDLE) && w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operands are frozen from accept until the block returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_op   <= 3'b000;
      r_id   <= 1'b0;
      r_prio <= RR_INIT;
    end else if (w_accept) begin
      r_a    <= w_gnt1 ? req1_a  : req0_a;
      r_b    <= w_gnt1 ? req1_b  : req0_b;
      r_op   <= w_gnt1 ? req1_op : req0_op;
      r_id   <= w_gnt1;
      r_prio <= ~w_gnt1;
    end
  end

  always_comb begin
    w_alu_data = 8'h00;
    w_alu_err  = 1'b0;
    case (r_op)
      3'b000: w_alu_data = r_a & r_b;
      3'b001: w_alu_data = r_a | r_b;
      3'b010: w_alu_data = r_a ^ r_b;
      3'b011: w_alu_data = ~r_a;
      3'b100: w_alu_data = {7'b0, r_a[r_b[2:0]]};
      3'b101: w_alu_data = {7'b0, r_a[0]} << r_b[2:0];
      default: begin
        w_alu_data = 8'h00;
        w_alu_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_alu_data;
      r_rsp_id    <= r_id;
      r_rsp_err   <= w_alu_err;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 8'h00;
      r_cnt1 <= 8'h00;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      if (w_rsp_done) begin
        if (r_rsp_id) begin
          r_cnt1 <= r_cnt1 + 8'd1;
        end else begin
          r_cnt0 <= r_cnt0 + 8'd1;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign done_cnt0 = r_cnt0;
  assign done_cnt1 = r_cnt1;
  assign busy      = r_busy;

endmodule

// File: doc/logic_alu_arbiter.md
# logic_alu_arbiter

Shares one 8-bit logic unit (AND/OR/XOR/NOT/MUX/DMUX, the same functions as the existing 8-bit gate library) between two requesters. The block uses round-robin arbitration with valid/ready request and response handshakes. Sequencing is IDLE → EXEC → RESP, with a registered result and per-requester completion counters. It sits between the two issuing blocks and the 8-bit gate datapath.

## Interface
- RR_INIT, 0: requester holding priority after reset (0 or 1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req1_a  in  8  operand A.
- req0_b, req1_b  in  8  operand B (bits [2:0] used as select for MUX/DMUX).
- req0_op, req1_op  in  3  opcode.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  result.
- rsp_id  out  1  requester that issued the result.
- rsp_err  out  1  illegal opcode flag.
- done_cnt0, done_cnt1  out  8  completed responses per requester, wrap 255→0.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE:** if any valid, grant one requester and capture its a, b, op and id; go to EXEC. With no valid, stay in IDLE.
- Arbitration: when only one valid, grant it. When both valid, grant the priority holder. After each grant, priority passes to the other requester.
- reqN_ready = (state==IDLE) && granted N; combinational from valids and priority, so at most one ready per cycle.
- Captured operands are held constant until return to IDLE; requester inputs are ignored outside IDLE.
- **EXEC:** compute from captured operands into the result register; go to RESP unconditionally.
- Opcodes:
  - 000: a&b.
  - 001: a|b.
  - 010: a^b.
  - 011: ~a.
  - 100: MUX, result = {7'b0, a[b[2:0]]}.
  - 101: DMUX, result = a[0] << b[2:0].
  - 110 and 111: illegal; rsp_data=8'h00, rsp_err=1.
  - rsp_err=0 for all legal opcodes.
- **RESP:** rsp_valid=1; rsp_data, rsp_id and rsp_err are stable. When rsp_ready=1: increment done_cnt[rsp_id] (mod 256, illegal ops included) and go to IDLE. Otherwise stay in RESP holding all outputs.
- No new request is accepted during EXEC/RESP, even if rsp_ready is high in RESP.
- Reset values:
  - state=IDLE, priority=RR_INIT.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - done_cnt0=0, done_cnt1=0, busy=0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no counter increment, and the reset values above apply the next cycle.

## Timing
- Cycle T: IDLE, valid seen, ready=1 (accept edge at end of T).
- Cycle T+1: EXEC.
- Cycle T+2: RESP, rsp_valid=1.
- Accept-to-response latency is 2 cycles.
- With rsp_ready already high at T+2: handshake at end of T+2, IDLE at T+3, next accept at T+3 at the earliest. Maximum throughput is 1 op per 3 cycles.
- Backpressure: each cycle of rsp_ready=0 in RESP adds one cycle. Outputs must not change while stalled.
- Counter increments are visible the cycle after the handshake.
- rsp_valid, rsp_data, rsp_id, rsp_err, done_cnt and busy are all registered. Only the ready signals are combinational.

## Test plan
- Reset, then req0: a=8'hF0, b=8'h3C, op=000 → req0_ready at T, rsp_valid at T+2, rsp_data=8'h30, rsp_id=0, done_cnt0=1.
- Both valid every cycle with RR_INIT=0. req0 op=010 a=8'hAA b=8'hFF; req1 op=011 a=8'h0F.
  - Grants alternate 0,1,0,1.
  - Responses alternate 8'h55 (id 0) and 8'hF0 (id 1).
  - After 4 responses: done_cnt0=2, done_cnt1=2.
- MUX/DMUX, req1:
  - op=100, a=8'b0010_0000, b=5 → 8'h01; b=4 → 8'h00.
  - op=101, a=8'h01, b=7 → 8'h80.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid held with data stable; req0_valid held high sees ready=0 throughout; accept occurs the cycle after the handshake.
- Illegal op=110 → rsp_err=1, rsp_data=8'h00, done_cnt incremented; next legal op → rsp_err=0.
- Reset asserted during EXEC, and separately during RESP → rsp_valid=0 next cycle, counters 0, priority=RR_INIT, busy=0. Also check done_cnt0 wraps 255→0 after 256 responses.
